// File: rtl/sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver
//
// Multiplexed seven-segment display driver. It scans NUM_DIGITS hex digits,
// holding each one for REFRESH_DIV clock cycles. Each digit can be masked
// individually. New display values are committed only at frame boundaries,
// so a frame never shows a mix of old and new digits.
//
// Parameters:
//   NUM_DIGITS  - number of scanned digits (1..16)
//   REFRESH_DIV - Clk cycles each digit is held (>= 1)
//   ACTIVE_LOW  - 1: segment and enable outputs are active-low
//
// Ports:
//   Clk       in   system clock
//   Rst       in   synchronous active-high reset
//   Value     in   hex value; nibble k drives digit k
//   Load      in   capture Value for display from the next frame
//   DigitMask in   1 = digit k enabled (live, not latched)
//   out7      out  segments {a,b,c,d,e,f,g}
//   en_out    out  digit enables, one-hot active
//   ScanDone  out  one-cycle pulse after the last slot of each frame
//
// Optional build macro:
//   SEVENSEG_LEADING_ZERO_BLANK_EN - blank the digits above the most
//   significant nonzero nibble of the displayed value (digit 0 always shown).
// ---------------------------------------------------------------------------
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    Load,
    input  logic [NUM_DIGITS-1:0]   DigitMask,
    output logic [6:0]              out7,
    output logic [NUM_DIGITS-1:0]   en_out,
    output logic                    ScanDone
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Hex digit to active-high {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    // Map active-high segment pattern to the output polarity.
    function automatic logic [6:0] seg_polarity(input logic [6:0] seg);
        return ACTIVE_LOW ? ~seg : seg;
    endfunction

    // Map active-high enable vector to the output polarity.
    function automatic logic [NUM_DIGITS-1:0] en_polarity(input logic [NUM_DIGITS-1:0] en);
        return ACTIVE_LOW ? ~en : en;
    endfunction

    localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    // Scan state
    logic [DIV_W-1:0]          div_cnt;
    logic [IDX_W-1:0]          idx;
    logic [4*NUM_DIGITS-1:0]   pending;
    logic [4*NUM_DIGITS-1:0]   disp;

    // Registered outputs
    logic [6:0]                out7_p1;
    logic [NUM_DIGITS-1:0]     en_p1;
    logic                      done_p1;

    logic                      div_wrap;
    logic                      frame_end;
    logic [3:0]                sel_nib;
    logic                      sel_mask;
    logic [NUM_DIGITS-1:0]     sel_onehot;
    logic                      blank;
    logic                      show;

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign frame_end = div_wrap && (idx == IDX_LAST);

    // Select the current digit's nibble, mask bit and enable position.
    // A compare loop keeps the selection in range for any NUM_DIGITS.
    always_comb begin
        sel_nib    = 4'h0;
        sel_mask   = 1'b0;
        sel_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_nib       = disp[4*k +: 4];
                sel_mask      = DigitMask[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    // Position of the most significant nonzero nibble of disp; stays 0 when
    // disp is zero so digit 0 is never blanked.
    logic [IDX_W-1:0] msd;

    always_comb begin
        msd = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (disp[4*k +: 4] != 4'h0) begin
                msd = IDX_W'(k);
            end
        end
    end

    assign blank = (idx > msd);
`else
    assign blank = 1'b0;
`endif

    assign show = sel_mask && !blank;

    // ---- stage p0 -> p1: scan counters, value commit, registered outputs ----
    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_cnt <= '0;
            idx     <= '0;
            pending <= '0;
            disp    <= '0;
            out7_p1 <= SEG_OFF;
            en_p1   <= EN_OFF;
            done_p1 <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);

            if (div_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end

            // A Load landing on the boundary goes straight to disp; pending
            // tracks it too so the following frame does not revert.
            if (Load) begin
                pending <= Value;
            end
            if (frame_end) begin
                disp <= Load ? Value : pending;
            end

            done_p1 <= frame_end;

            if (show) begin
                out7_p1 <= seg_polarity(seg_decode(sel_nib));
                en_p1   <= en_polarity(sel_onehot);
            end else begin
                out7_p1 <= SEG_OFF;
                en_p1   <= EN_OFF;
            end
        end
    end

    assign out7     = out7_p1;
    assign en_out   = en_p1;
    assign ScanDone = done_p1;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//
// Bench for sevenseg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=2,
// ACTIVE_LOW=1. Each driven cycle pushes the expected registered outputs
// into a queue; a negedge monitor pops one entry per cycle and compares.
// Expected digit contents per frame are stated explicitly by the stimulus.
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] Value;
    logic        Load;
    logic [3:0]  DigitMask;
    logic [6:0]  out7;
    logic [3:0]  en_out;
    logic        ScanDone;

    always #5 Clk = ~Clk;

    sevenseg_scan_driver #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(2),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Value    (Value),
        .Load     (Load),
        .DigitMask(DigitMask),
        .out7     (out7),
        .en_out   (en_out),
        .ScanDone (ScanDone)
    );

    typedef struct {
        logic [6:0] o7;
        logic [3:0] en;
        logic       done;
        int         tag;
    } exp_t;

    exp_t exp_q[$];

    // Active-low segment codes for hex 0..F
    logic [6:0] seg_al [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    int n_vec = 0;
    int n_bad = 0;
    int tag   = 0;

    task automatic push(input logic [6:0] o7, input logic [3:0] en, input logic done);
        exp_t e;
        e.o7   = o7;
        e.en   = en;
        e.done = done;
        e.tag  = tag;
        tag++;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Digits that remain visible after leading-zero blanking.
    function automatic logic [3:0] visible(input logic [15:0] v);
        logic [3:0] vis;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        int msd;
        msd = 0;
        for (int k = 0; k < 4; k++)
            if (v[4*k +: 4] != 4'h0) msd = k;
        vis = 4'h0;
        for (int k = 0; k <= msd; k++) vis[k] = 1'b1;
`else
        vis = 4'hF;
        if (v == 16'hFFFF) vis = 4'hF;
`endif
        return vis;
    endfunction

    // Drive nslots scan slots of one frame showing 'shown'. Loads of va/vb
    // happen at slots la/lb (-1 = none).
    task automatic run_frame(input logic [15:0] shown, input logic [3:0] mask, input int nslots,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb);
        for (int j = 0; j < nslots; j++) begin
            int         d;
            logic [3:0] nib;
            logic [3:0] vis;
            logic [3:0] en_exp;
            d         = j / 2;
            Load      = (j == la) || (j == lb);
            Value     = (j == la) ? va : ((j == lb) ? vb : 16'hC0DE);
            DigitMask = mask;
            nib       = shown[4*d +: 4];
            vis       = visible(shown);
            en_exp    = ~(4'b0001 << d);
            if (mask[d] && vis[d]) push(seg_al[nib], en_exp, j == 7);
            else                   push(7'h7F, 4'hF, j == 7);
            tick();
        end
        Load = 1'b0;
    endtask

    task automatic reset_cycle(input logic ld, input logic [15:0] v);
        Rst   = 1'b1;
        Load  = ld;
        Value = v;
        push(7'h7F, 4'hF, 1'b0);
        tick();
    endtask

    // Monitor: one output per cycle, compared against the queue head.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (out7 !== e.o7 || en_out !== e.en || ScanDone !== e.done) begin
                n_bad++;
                $display("FAIL vec%0d: got out7=%h en_out=%h ScanDone=%b, expected out7=%h en_out=%h ScanDone=%b",
                         e.tag, out7, en_out, ScanDone, e.o7, e.en, e.done);
            end
        end
    end

    initial begin
        Rst       = 1'b1;
        Load      = 1'b0;
        Value     = 16'h0;
        DigitMask = 4'hF;

        // Two reset cycles
        reset_cycle(1'b0, 16'h0);
        reset_cycle(1'b1, 16'h4321);
        Rst = 1'b0;

        // Frame 0 shows reset value 0; Load 1234 in its first cycle
        run_frame(16'h0000, 4'hF, 8, 0, 16'h1234, -1, 16'h0);
        // Frame 1 shows 1234; AAAA then 5555 loaded mid-frame
        run_frame(16'h1234, 4'hF, 8, 2, 16'hAAAA, 5, 16'h5555);
        // Frame 2 shows 5555 only; BEEF loaded in the boundary cycle
        run_frame(16'h5555, 4'hF, 8, 7, 16'hBEEF, -1, 16'h0);
        // Frame 3 shows BEEF directly; queue 1234 for the next frame
        run_frame(16'hBEEF, 4'hF, 8, 3, 16'h1234, -1, 16'h0);
        // Frame 4: digits 1 and 3 masked; queue AAAA
        run_frame(16'h1234, 4'b0101, 8, 1, 16'hAAAA, -1, 16'h0);
        // Frame 5: digits 0,1 then reset in the digit 2 slot; pending 3333 dropped
        run_frame(16'hAAAA, 4'hF, 4, 1, 16'h3333, -1, 16'h0);
        reset_cycle(1'b1, 16'h9999);
        Rst = 1'b0;
        // Fresh frame from digit 0 with disp=0; load 0007
        run_frame(16'h0000, 4'hF, 8, 0, 16'h0007, -1, 16'h0);
        run_frame(16'h0007, 4'hF, 8, -1, 16'h0, -1, 16'h0);

        repeat (2) @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected outputs never compared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
